alu_exec_unit: RTL

Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder, together with two register operands, and returns a result, a high word and condition flags. Add/sub/logic/shift/rotate complete in one cycle. Signed multiply and divide run on an iterative shift-add/shift-subtract engine over multiple cycles. The unit sits between the ALU control decoder and the writeback/branch logic and stalls the pipeline through a start/busy/done handshake.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_muldiv_seq.sv | 94 +++++++++
 rtl/alu_exec_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: control codes (also used by the
// ALU control decoder), FSM state encoding and a small classification helper.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_MUL = 4'b0100;
    localparam logic [3:0] ALU_DIV = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_ROL = 4'b1000;
    localparam logic [3:0] ALU_ROR = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } alu_state_e;

    function automatic logic is_multicycle(input logic [3:0] code);
        return (code == ALU_MUL) || (code == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative signed multiply/divide engine: works on operand magnitudes for WIDTH
// steps, then presents sign-corrected results combinationally for the fix-up cycle.
module alu_muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic             dz_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, mb_q, a_q;
    logic [CNT_W-1:0] cnt_q;
    logic             div_q, neg_lo_q, neg_hi_q, dz_q;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum, sh, diff;
    logic [2*WIDTH-1:0] prod_fix;

    assign a_mag = a_i[WIDTH-1] ? ('0 - a_i) : a_i;
    assign b_mag = b_i[WIDTH-1] ? ('0 - b_i) : b_i;

    // MUL: {acc,q} shifts right with a conditional add; DIV: restoring subtract into acc.
    always_comb begin
        sum  = {1'b0, acc_q} + (q_q[0] ? {1'b0, mb_q} : '0);
        sh   = {acc_q, q_q[WIDTH-1]};
        diff = sh - {1'b0, mb_q};
        if (div_q) begin
            if (!diff[WIDTH]) begin
                acc_d = diff[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = sh[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = sum[WIDTH:1];
            q_d   = {sum[0], q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            q_q      <= '0;
            mb_q     <= '0;
            a_q      <= '0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
        end else if (load_i) begin
            acc_q    <= '0;
            q_q      <= a_mag;
            mb_q     <= b_mag;
            a_q      <= a_i;
            cnt_q    <= '0;
            div_q    <= is_div_i;
            neg_lo_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
            neg_hi_q <= a_i[WIDTH-1];
            dz_q     <= is_div_i && (b_i == '0);
        end else if (step_i) begin
            acc_q <= acc_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign last_o   = (cnt_q == CNT_W'(WIDTH - 1));
    assign dz_o     = dz_q;
    assign prod_fix = neg_lo_q ? ('0 - {acc_q, q_q}) : {acc_q, q_q};

    always_comb begin
        if (dz_q) begin
            lo_o = '1;
            hi_o = a_q;
        end else if (div_q) begin
            lo_o = neg_lo_q ? ('0 - q_q) : q_q;
            hi_o = neg_hi_q ? ('0 - acc_q) : acc_q;
        end else begin
            lo_o = prod_fix[WIDTH-1:0];
            hi_o = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic/shift datapath plus a
// start/busy/done FSM wrapping the iterative multiply/divide engine.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic             flag_ovf,
    output logic             flag_dz,
    output logic             flag_ill,
    output logic [1:0]       dbg_state
);
    localparam int SH_W = $clog2(WIDTH);

    alu_state_e       state_q;
    logic             busy_q, done_q, zero_q, neg_q, ovf_q, dz_q, ill_q;
    logic [WIDTH-1:0] res_q, hi_q;

    logic             accept, is_md;
    logic [SH_W-1:0]  shamt, nshamt;
    logic [WIDTH-1:0] add_r, sub_r, sc_res;
    logic             sc_ovf, sc_ill;
    logic             md_last, md_dz;
    logic [WIDTH-1:0] md_lo, md_hi;

    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign is_md  = is_multicycle(alu_ctrl);
    assign shamt  = op_b[SH_W-1:0];
    assign nshamt = '0 - shamt;  // complementary rotate distance; zero stays zero
    assign add_r  = op_a + op_b;
    assign sub_r  = op_a - op_b;

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        case (alu_ctrl)
            ALU_ADD: begin
                sc_res = add_r;
                sc_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_r[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_res = sub_r;
                sc_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_r[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_AND: sc_res = op_a & op_b;
            ALU_OR:  sc_res = op_a | op_b;
            ALU_MUL, ALU_DIV: sc_res = '0;
            ALU_SLL: sc_res = op_a << shamt;
            ALU_SRL: sc_res = op_a >> shamt;
            ALU_ROL: sc_res = (op_a << shamt) | (op_a >> nshamt);
            ALU_ROR: sc_res = (op_a >> shamt) | (op_a << nshamt);
            default: sc_ill = 1'b1;
        endcase
    end

    alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept && is_md),
        .step_i   (state_q == ST_ITER),
        .is_div_i (alu_ctrl == ALU_DIV),
        .a_i      (op_a),
        .b_i      (op_b),
        .last_o   (md_last),
        .dz_o     (md_dz),
        .lo_o     (md_lo),
        .hi_o     (md_hi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept && is_md) begin
                        state_q <= ST_ITER;
                        busy_q  <= 1'b1;
                    end else if (accept) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        res_q   <= sc_res;
                        hi_q    <= '0;
                        zero_q  <= (sc_res == '0);
                        neg_q   <= sc_res[WIDTH-1];
                        ovf_q   <= sc_ovf;
                        dz_q    <= 1'b0;
                        ill_q   <= sc_ill;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ITER: if (md_last) state_q <= ST_FIXUP;
                ST_FIXUP: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    res_q   <= md_lo;
                    hi_q    <= md_hi;
                    zero_q  <= (md_lo == '0);
                    neg_q   <= md_lo[WIDTH-1];
                    ovf_q   <= 1'b0;
                    dz_q    <= md_dz;
                    ill_q   <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = res_q;
    assign result_hi = hi_q;
    assign flag_zero = zero_q;
    assign flag_neg  = neg_q;
    assign flag_ovf  = ovf_q;
    assign flag_dz   = dz_q;
    assign flag_ill  = ill_q;
    assign dbg_state = state_q;

endmodule
